// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the shared regfile write port, with a registered write stage and busy scoreboard.
// Optional WB_FWD_EN macro adds forwarding outputs from the staged write and relaxes RAW checks.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid_i,
    input  logic [4:0]              issue_rd_i,
    input  logic [4:0]              rs1_id_i,
    input  logic [4:0]              rs2_id_i,
    output logic                    hazard_o,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*5-1:0]    req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0] req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    w_en_o,
    output logic [4:0]              rd_id_o,
    output logic [XLEN-1:0]         rd_write_data_o,
`ifdef WB_FWD_EN
    output logic                    rs1_fwd_o,
    output logic                    rs2_fwd_o,
    output logic [XLEN-1:0]         fwd_data_o,
`endif
    output logic [31:0]             busy_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 2) ? 2 : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             w_en_q, w_en_d;
    logic [4:0]       rd_id_q, rd_id_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [31:0]      busy_q, busy_d;

    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    logic             found;
    logic [4:0]       win_rd;
    logic [XLEN-1:0]  win_data;
    logic             rs1_b, rs2_b, rd_b;

    // Search starts one past the last winner and wraps; first valid requester wins.
    always_comb begin
        win         = '0;
        idx         = '0;
        found       = 1'b0;
        req_ready_o = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            req_ready_o[win] = 1'b1;
        end
    end

    assign win_rd   = req_rd_i[win*5 +: 5];
    assign win_data = req_data_i[win*XLEN +: XLEN];

    // A source being written this cycle is satisfied by the forward path when enabled.
    always_comb begin
        rd_b  = (issue_rd_i != 5'd0) && busy_q[issue_rd_i];
`ifdef WB_FWD_EN
        rs1_b = (rs1_id_i != 5'd0) && busy_q[rs1_id_i] && !(w_en_q && (rd_id_q == rs1_id_i));
        rs2_b = (rs2_id_i != 5'd0) && busy_q[rs2_id_i] && !(w_en_q && (rd_id_q == rs2_id_i));
`else
        rs1_b = (rs1_id_i != 5'd0) && busy_q[rs1_id_i];
        rs2_b = (rs2_id_i != 5'd0) && busy_q[rs2_id_i];
`endif
        hazard_o = issue_valid_i && (rs1_b || rs2_b || rd_b);
    end

    // Next state: write stage capture, pointer advance, scoreboard clear then set (set wins).
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        w_en_d   = 1'b0;
        rd_id_d  = rd_id_q;
        data_d   = data_q;
        busy_d   = busy_q;
        if (found) begin
            rr_ptr_d = win;
            if (win_rd != 5'd0) begin
                w_en_d  = 1'b1;
                rd_id_d = win_rd;
                data_d  = win_data;
            end
        end
        if (w_en_q) begin
            busy_d[rd_id_q] = 1'b0;
        end
        if (issue_valid_i && !hazard_o && (issue_rd_i != 5'd0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
            w_en_q   <= 1'b0;
            rd_id_q  <= '0;
            data_q   <= '0;
            busy_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            w_en_q   <= w_en_d;
            rd_id_q  <= rd_id_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign w_en_o          = w_en_q;
    assign rd_id_o         = rd_id_q;
    assign rd_write_data_o = data_q;
    assign busy_o          = busy_q;

`ifdef WB_FWD_EN
    assign rs1_fwd_o  = w_en_q && (rd_id_q == rs1_id_i) && (rs1_id_i != 5'd0);
    assign rs2_fwd_o  = w_en_q && (rd_id_q == rs2_id_i) && (rs2_id_i != 5'd0);
    assign fwd_data_o = data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes queued at grant time, a monitor checks commits.
module tb_regfile_wb_arbiter;

    localparam int N    = 3;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid_i;
    logic [4:0]      issue_rd_i, rs1_id_i, rs2_id_i;
    logic            hazard_o;
    logic [N-1:0]    req_valid_i;
    logic [N*5-1:0]  req_rd_i;
    logic [N*XLEN-1:0] req_data_i;
    logic [N-1:0]    req_ready_o;
    logic            w_en_o;
    logic [4:0]      rd_id_o;
    logic [XLEN-1:0] rd_write_data_o;
    logic [31:0]     busy_o;
`ifdef WB_FWD_EN
    logic            rs1_fwd_o, rs2_fwd_o;
    logic [XLEN-1:0] fwd_data_o;
`endif

    regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i), .hazard_o(hazard_o),
        .req_valid_i(req_valid_i), .req_rd_i(req_rd_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .w_en_o(w_en_o), .rd_id_o(rd_id_o),
        .rd_write_data_o(rd_write_data_o),
`ifdef WB_FWD_EN
        .rs1_fwd_o(rs1_fwd_o), .rs2_fwd_o(rs2_fwd_o), .fwd_data_o(fwd_data_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        int              due;
    } wr_t;
    wr_t expq[$];
    wr_t mon_e;

    // Requester and decode stimulus state
    bit              rv   [N];
    logic [4:0]      rrd  [N];
    logic [XLEN-1:0] rdat [N];
    bit              iv;
    logic [4:0]      ird, irs1, irs2;
    logic [4:0]      outq[$];

    // Reference model: last winner, busy set, and the write currently visible on the port
    int              ptr;
    logic [31:0]     mbusy;
    bit              mwen;
    logic [4:0]      mrd;
    logic [XLEN-1:0] mdata;
    bit              last_haz;
    logic [N-1:0]    last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit bz(input logic [4:0] r, input bit is_src);
        if (r == 5'd0) return 1'b0;
`ifdef WB_FWD_EN
        if (is_src && mwen && mrd == r) return 1'b0;
`else
        if (is_src && 1'b0) return 1'b0;
`endif
        return mbusy[r];
    endfunction

    // Commit monitor: every regfile write must match the oldest expected write, on time.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (w_en_o) begin
                    if (expq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: rd=%0d data=%0h none expected", rd_id_o, rd_write_data_o);
                    end else begin
                        mon_e = expq.pop_front();
                        chk("wr_rd", 64'(rd_id_o), 64'(mon_e.rd));
                        chk("wr_data", 64'(rd_write_data_o), 64'(mon_e.data));
                        chk("wr_cycle", 64'(cyc), 64'(mon_e.due));
                    end
                end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_write: got w_en_o=0 expected rd=%0d data=%0h", expq[0].rd, expq[0].data);
                    void'(expq.pop_front());
                end
            end
        end
    end

    // One clock: drive at negedge, check comb/registered outputs, advance the model.
    task automatic cycle();
        int w;
        bit haz;
        logic [31:0] nb;
        issue_valid_i = iv; issue_rd_i = ird; rs1_id_i = irs1; rs2_id_i = irs2;
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]          = rv[i];
            req_rd_i[5*i +: 5]      = rrd[i];
            req_data_i[XLEN*i +: XLEN] = rdat[i];
        end
        #1;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (w < 0 && rv[j]) w = j;
        end
        haz = iv && (bz(irs1, 1'b1) || bz(irs2, 1'b1) || bz(ird, 1'b0));
        last_ready = (w < 0) ? '0 : N'(1 << w);
        chk("ready", 64'(req_ready_o), 64'(last_ready));
        chk("hazard", 64'(hazard_o), 64'(haz));
        chk("busy", 64'(busy_o), 64'(mbusy));
`ifdef WB_FWD_EN
        chk("rs1_fwd", 64'(rs1_fwd_o), 64'(mwen && mrd == irs1 && irs1 != 5'd0));
        chk("rs2_fwd", 64'(rs2_fwd_o), 64'(mwen && mrd == irs2 && irs2 != 5'd0));
        if (mwen) chk("fwd_data", 64'(fwd_data_o), 64'(mdata));
`endif
        nb = mbusy;
        if (mwen) nb[mrd] = 1'b0;
        if (iv && !haz && ird != 5'd0) begin
            nb[ird] = 1'b1;
            outq.push_back(ird);
        end
        mwen = 1'b0;
        if (w >= 0) begin
            ptr = w;
            if (rrd[w] != 5'd0) begin
                expq.push_back('{rd: rrd[w], data: rdat[w], due: cyc + 1});
                mwen  = 1'b1;
                mrd   = rrd[w];
                mdata = rdat[w];
            end
            rv[w] = 1'b0;
        end
        mbusy    = nb;
        last_haz = haz;
        @(negedge clk);
    endtask

    task automatic do_reset(input int ncyc, input bit clear_req);
        rst = 1'b0;
        expq.delete();
        outq.delete();
        #1;
        chk("rst_w_en", 64'(w_en_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        repeat (ncyc) @(negedge clk);
        chk("rst_w_en_hold", 64'(w_en_o), 64'd0);
        chk("rst_rd_id", 64'(rd_id_o), 64'd0);
        chk("rst_data", 64'(rd_write_data_o), 64'd0);
        ptr = N - 1; mbusy = '0; mwen = 1'b0; mrd = '0; mdata = '0; last_haz = 1'b0;
        if (clear_req) for (int i = 0; i < N; i++) rv[i] = 1'b0;
        rst = 1'b1;
    endtask

    task automatic gen();
        int idx;
        for (int i = 0; i < N; i++) begin
            if (!rv[i] && $urandom_range(0, 1) == 1) begin
                rv[i] = 1'b1;
                if (outq.size() > 0 && $urandom_range(0, 3) != 0) begin
                    idx = $urandom_range(0, outq.size() - 1);
                    rrd[i] = outq[idx];
                    outq.delete(idx);
                end else begin
                    rrd[i] = 5'($urandom_range(0, 7));
                end
                rdat[i] = $urandom;
            end
        end
        if (!last_haz) begin
            iv   = ($urandom_range(0, 2) != 0);
            ird  = 5'($urandom_range(0, 7));
            irs1 = 5'($urandom_range(0, 7));
            irs2 = 5'($urandom_range(0, 7));
        end
    endtask

    initial begin
        iv = 1'b0; ird = '0; irs1 = '0; irs2 = '0;
        issue_valid_i = 1'b0; issue_rd_i = '0; rs1_id_i = '0; rs2_id_i = '0;
        req_valid_i = '0; req_rd_i = '0; req_data_i = '0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1; rrd[i] = 5'(i + 10); rdat[i] = 32'hA000_0000 + 32'(i);
            req_valid_i[i] = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);

        // Reset with all requesters valid, then round-robin 0,1,2,0,1,2
        do_reset(2, 1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) if (!rv[i]) begin
                rv[i] = 1'b1; rrd[i] = 5'(i + 10); rdat[i] = 32'hB000_0000 + 32'(k * 8 + i);
            end
            cycle();
            chk("rr_seq", 64'(last_ready), 64'(1 << (k % 3)));
        end
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        repeat (2) cycle();

        // RAW: issue rd=5, then a reader of x5 stalls until LSU commits 0xDEADBEEF
        iv = 1'b1; ird = 5'd5; irs1 = 5'd0; irs2 = 5'd0;
        cycle();
        iv = 1'b1; ird = 5'd0; irs1 = 5'd5;
        cycle();
        chk("raw_stall", 64'(last_haz), 64'd1);
        rv[1] = 1'b1; rrd[1] = 5'd5; rdat[1] = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) cycle();
        chk("raw_released", 64'(last_haz), 64'd0);
        iv = 1'b0; irs1 = 5'd0;
        cycle();

        // WAW: rd=7 busy, re-issue of rd=7 stalls until its commit, then sets busy again
        iv = 1'b1; ird = 5'd7;
        cycle();
        rv[0] = 1'b1; rrd[0] = 5'd7; rdat[0] = 32'h0000_0077;
        for (int k = 0; k < 4; k++) cycle();
        iv = 1'b0; ird = 5'd0;
        cycle();
        chk("waw_busy7", 64'(busy_o[7]), 64'd1);
        rv[2] = 1'b1; rrd[2] = 5'd7; rdat[2] = 32'h0000_0777;
        repeat (3) cycle();

        // rd=0 request is granted but never written
        rv[0] = 1'b1; rrd[0] = 5'd0; rdat[0] = 32'h0000_1234;
        cycle();
        chk("rd0_ready", 64'(last_ready), 64'd1);
        cycle();
        chk("rd0_no_write", 64'(w_en_o), 64'd0);

        // Reset between accept and commit of x3
        iv = 1'b1; ird = 5'd3;
        cycle();
        iv = 1'b0; ird = 5'd0;
        rv[2] = 1'b1; rrd[2] = 5'd3; rdat[2] = 32'h0000_0333;
        cycle();
        chk("mid_wen_before", 64'(w_en_o), 64'd1);
        do_reset(2, 1'b1);
        chk("mid_busy_after", 64'(busy_o), 64'd0);
        cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 2000; k++) begin
            gen();
            cycle();
        end

        // Drain: no new work, bounded wait for outstanding requests
        iv = 1'b0;
        for (int k = 0; k < 50; k++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= rv[i];
            if (!any) break;
            cycle();
        end
        repeat (3) cycle();
        chk("drain_reqs", 64'({rv[0], rv[1], rv[2]}), 64'd0);
        chk("drain_expq", 64'(expq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
